shift_unit: RTL
===============

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter TAG_W, default 4: width of destination-register tag carried with each operation.
REQ-002 Parameter DATA_W, default 32: operand/result width; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 flush  input  1  synchronous kill of all in-flight operations.
REQ-006 in_valid  input  1  upstream operation present.
REQ-007 in_ready  output  1  unit accepts an operation this cycle.
REQ-008 in_data  input  32  operand to shift.
REQ-009 in_sh  input  5  shift amount, 0..31.
REQ-010 in_ftn  input  3  shift function code.
REQ-011 in_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream consumes the result this cycle.
REQ-014 out_data  output  32  shifted result.
REQ-015 out_tag  output  TAG_W  tag of out_data.
REQ-016 out_z / out_n / out_c  output  1 each  zero, negative, carry flags of out_data.

Function
REQ-017 Two registered stages: S1 holds the accepted operands; S2 holds the result, tag and flags; the combinational shifter sits between S1 and S2.
REQ-018 Accept on in_valid && in_ready; out_valid asserts exactly 2 cycles after acceptance when no stall occurs.
REQ-019 S2 advances when !s2_valid || out_ready; S1 advances into S2 under the same condition.
REQ-020 in_ready = !s1_valid || S2-advance; back-to-back acceptance every cycle when out_ready is held high.
REQ-021 Under out_ready low, out_data/out_tag/flags stay stable and out_valid stays high until consumed.
REQ-022 Function codes: 0 pass, 1 LSL, 2 LSR, 3 ASR, 4 ROL, 5 ROR, 6 pass, 7 pass.
REQ-023 out_z = (out_data == 0); out_n = out_data[31].
REQ-024 out_c: LSL in_data[32-SH]; LSR/ASR in_data[SH-1]; ROL result[0]; ROR result[31]; 0 when SH == 0 or the function is pass.
REQ-025 SH == 0 for any function yields out_data = in_data and out_c = 0.
REQ-026 flush clears s1_valid and s2_valid on the next edge; any in_valid in the flush cycle is dropped, and in_ready is forced low during flush.
REQ-027 Simultaneous S2 consume and S1 advance in one cycle shall lose no operation and duplicate none.

Reset
REQ-028 rst_n low asynchronously clears s1_valid and s2_valid, so out_valid = 0; out_data, out_tag and all flags = 0.
REQ-029 After rst_n deasserts, in_ready = 1 on the first cycle.
REQ-030 Reset asserted mid-operation discards all in-flight operations; none is emitted after reset.

Structure
REQ-031 Function-code constants (FTN_PASS, FTN_LSL, FTN_LSR, FTN_ASR, FTN_ROL, FTN_ROR) and DATA_W belong in the shared RISC package used by the shifter and by decode.
REQ-032 The existing combinational shifter is instantiated once as the sole sub-module (shifter: shift_in, SH, ftn, shift_out); carry logic lives in shift_unit.

Verification
REQ-033 in_data 0x35FFFF15, SH 8, ftn LSL -> out_data 0xFFFF1500, c=1, n=1, z=0, two cycles after acceptance.
REQ-034 Same operand with LSR -> 0x0035FFFF, c=0; with ASR -> 0x0035FFFF; with ROR -> 0x1535FFFF, c=0.
REQ-035 in_data 0x80000000, SH 31, ASR -> 0xFFFFFFFF, n=1, c=0; the same with LSR -> 0x00000001, c=0.
REQ-036 Stream 8 operations with out_ready low for cycles 3..6 -> exactly 8 results, in order, with tags intact; in_ready low while both stages are full.
REQ-037 flush, or rst_n pulse, with both stages full -> out_valid 0 next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared RISC definitions used by the shifter, the shift unit and decode.
package shift_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SH_W   = 5;

  // Shift function codes; codes 6 and 7 are treated as pass-through.
  typedef enum logic [2:0] {
    FTN_PASS = 3'd0,
    FTN_LSL  = 3'd1,
    FTN_LSR  = 3'd2,
    FTN_ASR  = 3'd3,
    FTN_ROL  = 3'd4,
    FTN_ROR  = 3'd5
  } ftn_e;

endpackage

// File: rtl/shift_unit_shifter.sv
// Combinational barrel shifter: logical/arithmetic shifts and rotates.
module shifter
  import shift_unit_pkg::*;
(
  input  logic [DATA_W-1:0] shift_in,
  input  logic [SH_W-1:0]   SH,
  input  logic [2:0]        ftn,
  output logic [DATA_W-1:0] shift_out
);

  // Rotates are built from two opposing shifts; a shift by 32 yields zero,
  // so SH == 0 degenerates cleanly to pass-through.
  always_comb begin
    shift_out = shift_in;
    case (ftn)
      FTN_LSL: shift_out = shift_in << SH;
      FTN_LSR: shift_out = shift_in >> SH;
      FTN_ASR: shift_out = $unsigned($signed(shift_in) >>> SH);
      FTN_ROL: shift_out = (shift_in << SH) | (shift_in >> (6'd32 - {1'b0, SH}));
      FTN_ROR: shift_out = (shift_in >> SH) | (shift_in << (6'd32 - {1'b0, SH}));
      default: shift_out = shift_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Two-stage pipelined shift unit with valid/ready handshake and Z/N/C flags.
module shift_unit #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_sh,
  input  logic [2:0]        in_ftn,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_z,
  output logic              out_n,
  output logic              out_c
);
  import shift_unit_pkg::*;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [4:0]        s1_sh;
  logic [2:0]        s1_ftn;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [TAG_W-1:0]  s2_tag;
  logic              s2_z, s2_n, s2_c;

  logic              s2_adv;
  logic [DATA_W-1:0] sh_res;
  logic              carry;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !flush && (!s1_valid || s2_adv);

  shifter u_shifter (
    .shift_in  (s1_data),
    .SH        (s1_sh),
    .ftn       (s1_ftn),
    .shift_out (sh_res)
  );

  // Carry is the last bit shifted out; 0 - SH in 5 bits gives 32 - SH for SH 1..31.
  always_comb begin
    carry = 1'b0;
    if (s1_sh != '0) begin
      case (s1_ftn)
        FTN_LSL: carry = s1_data[5'd0 - s1_sh];
        FTN_LSR,
        FTN_ASR: carry = s1_data[s1_sh - 5'd1];
        FTN_ROL: carry = sh_res[0];
        FTN_ROR: carry = sh_res[DATA_W-1];
        default: carry = 1'b0;
      endcase
    end
  end

  // Stage 1: capture operands when accepted; empties when it moves on with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sh    <= '0;
      s1_ftn   <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_sh   <= in_sh;
        s1_ftn  <= in_ftn;
        s1_tag  <= in_tag;
      end
    end
  end

  // Stage 2: register shifter result, tag and flags; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
      s2_c     <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sh_res;
        s2_tag  <= s1_tag;
        s2_z    <= (sh_res == '0);
        s2_n    <= sh_res[DATA_W-1];
        s2_c    <= carry;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign out_z     = s2_z;
  assign out_n     = s2_n;
  assign out_c     = s2_c;

endmodule
